// File: rtl/drawbridge_sequencer.sv
// drawbridge_sequencer: warn -> raise -> hold -> lower sequencer for the bridge deck motor.
// Define TRAVEL_WATCHDOG_EN to add the travel watchdog, the limit-conflict check and the FAULT state.
module drawbridge_sequencer #(
  parameter int WARN_CYCLES = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int TRAVEL_MAX  = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BoatReq,
  input  logic       BoatClear,
  input  logic       DeckClear,
  input  logic       TopLim,
  input  logic       BotLim,
  input  logic       FaultClr,
  output logic       MotorUp,
  output logic       MotorDown,
  output logic       AL,
  output logic       TFL,
  output logic       Fault,
  output logic [2:0] State
);

  localparam int MAX_WH  = (WARN_CYCLES > HOLD_CYCLES) ? WARN_CYCLES : HOLD_CYCLES;
  localparam int MAX_ALL = (MAX_WH > TRAVEL_MAX) ? MAX_WH : TRAVEL_MAX;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  localparam logic [CW-1:0] WARN_LAST = CW'(WARN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef TRAVEL_WATCHDOG_EN
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_MAX - 1);
`endif

  typedef enum logic [2:0] {
    FLAT     = 3'd0,
    WARN     = 3'd1,
    RAISING  = 3'd2,
    RAISED   = 3'd3,
    LOWERING = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t        state, state_seq, state_next;
  logic [CW-1:0] cnt, cnt_seq, cnt_next, cnt_inc;
  logic          motor_up_next, motor_down_next, al_next, tfl_next, fault_next;

  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  // Sequencing rules per state; cnt is cleared on any state change below.
  always_comb begin
    state_seq = state;
    cnt_seq   = cnt;
    case (state)
      FLAT: begin
        if (BoatReq) state_seq = WARN;
        else         state_seq = FLAT;
      end
      WARN: begin
        if (!BoatReq)              state_seq = FLAT;
        else if (!DeckClear)       cnt_seq   = {CW{1'b0}};
        else if (cnt == WARN_LAST) state_seq = RAISING;
        else                       cnt_seq   = cnt_inc;
      end
      RAISING: begin
        if (TopLim) state_seq = RAISED;
`ifdef TRAVEL_WATCHDOG_EN
        else if (MotorUp && cnt == TRAVEL_LAST) state_seq = FAULT;
        else if (MotorUp)                       cnt_seq   = cnt_inc;
`endif
        else state_seq = RAISING;
      end
      RAISED: begin
        if (BoatClear && !BoatReq) begin
          if (cnt == HOLD_LAST) state_seq = LOWERING;
          else                  cnt_seq   = cnt_inc;
        end else begin
          cnt_seq = {CW{1'b0}};
        end
      end
      LOWERING: begin
        if (BotLim)       state_seq = FLAT;
        else if (BoatReq) state_seq = RAISING;
`ifdef TRAVEL_WATCHDOG_EN
        else if (MotorDown && cnt == TRAVEL_LAST) state_seq = FAULT;
        else if (MotorDown)                       cnt_seq   = cnt_inc;
`endif
        else state_seq = LOWERING;
      end
`ifdef TRAVEL_WATCHDOG_EN
      FAULT: begin
        if (FaultClr && BotLim && !TopLim) state_seq = FLAT;
        else                               state_seq = FAULT;
      end
`endif
      default: state_seq = FLAT;
    endcase

`ifdef TRAVEL_WATCHDOG_EN
    state_next = (TopLim && BotLim) ? FAULT : state_seq;
`else
    state_next = state_seq;
`endif
    cnt_next = (state_next != state) ? {CW{1'b0}} : cnt_seq;

    // Entering RAISING from LOWERING holds MotorUp off for one dead-time cycle.
    motor_up_next   = (state_next == RAISING) && (state != LOWERING);
    motor_down_next = (state_next == LOWERING);
    al_next         = (state_next == WARN) || (state_next == RAISING) ||
                      (state_next == LOWERING) || (state_next == FAULT);
    tfl_next        = (state_next != FLAT);
    fault_next      = (state_next == FAULT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= FLAT;
      cnt       <= {CW{1'b0}};
      MotorUp   <= 1'b0;
      MotorDown <= 1'b0;
      AL        <= 1'b0;
      TFL       <= 1'b0;
      Fault     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      MotorUp   <= motor_up_next;
      MotorDown <= motor_down_next;
      AL        <= al_next;
      TFL       <= tfl_next;
`ifdef TRAVEL_WATCHDOG_EN
      Fault     <= fault_next;
`else
      Fault     <= 1'b0;
`endif
    end
  end

  assign State = state;

`ifndef TRAVEL_WATCHDOG_EN
  logic unused_inputs;
  assign unused_inputs = FaultClr ^ fault_next;
`endif

endmodule
